// File: rtl/ret_stack_if.sv
`default_nettype none
// ============================================================================
//  Module   : ret_stack_if
//  Brief    : Sequencer-side bundle for the return-address stack: operation
//             requests in, registered stack status out.
//  Revision : 1.0  initial release
// ============================================================================
interface ret_stack_if #(
    parameter int AW    = 15,
    parameter int DEPTH = 16,
    parameter int PW    = $clog2(DEPTH + 1)
);
    logic          push;
    logic          pop;
    logic [AW-1:0] push_data;
    logic          push_irq;
    logic          flush;
    logic          err_clr;
    logic [AW-1:0] top;
    logic          top_irq;
    logic [PW-1:0] depth;
    logic          full;
    logic          empty;
    logic [PW-1:0] irq_nest;
    logic          irq_ret;
    logic          ovf_err;
    logic          unf_err;

    // Address sequencer side: issues stack operations, observes status.
    modport master (
        output push, pop, push_data, push_irq, flush, err_clr,
        input  top, top_irq, depth, full, empty, irq_nest, irq_ret,
               ovf_err, unf_err
    );

    // Stack controller side.
    modport slave (
        input  push, pop, push_data, push_irq, flush, err_clr,
        output top, top_irq, depth, full, empty, irq_nest, irq_ret,
               ovf_err, unf_err
    );
endinterface
`default_nettype wire

// File: rtl/ret_stack_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ret_stack_ctrl
//  Brief    : Parametrised return-address stack with per-entry interrupt tag,
//             drop-or-overwrite overflow handling, sticky error flags and a
//             synchronous flush. All status outputs are registered.
//  Revision : 1.0  initial release
// ============================================================================
module ret_stack_ctrl #(
    parameter int AW       = 15,
    parameter int DEPTH    = 16,
    parameter int OVF_MODE = 0
) (
    input  wire logic   clk,
    input  wire logic   rst,
    ret_stack_if.slave  bus
);
    localparam int            PW      = $clog2(DEPTH + 1);
    localparam int            IW      = $clog2(DEPTH);
    localparam logic [PW-1:0] C_DEPTH = PW'(DEPTH);
    localparam logic [PW-1:0] C_ONE   = PW'(1);

    // Entry layout: {tag, address}. Storage is a ring: r_base is the oldest
    // slot, the top sits at r_base + r_cnt - 1 (mod DEPTH).
    logic [AW:0]    r_mem [DEPTH];
    logic [IW-1:0]  r_base;
    logic [PW-1:0]  r_cnt;
    logic [PW-1:0]  r_nest;
    logic [AW-1:0]  r_top;
    logic           r_top_irq;
    logic           r_ret;
    logic           r_ovf;
    logic           r_unf;
    logic           r_full;
    logic           r_empty;

    logic [IW-1:0]  w_cnt_lo;
    logic [IW-1:0]  w_top_idx;
    logic [IW-1:0]  w_below_idx;
    logic [IW-1:0]  w_wr_idx;
    logic [AW:0]    w_old;
    logic [AW:0]    w_below;
    logic [AW:0]    w_oldest;
    logic           w_is_full;
    logic           w_is_empty;

    logic [IW-1:0]  w_base_nxt;
    logic [PW-1:0]  w_cnt_nxt;
    logic [PW-1:0]  w_nest_nxt;
    logic [AW-1:0]  w_top_nxt;
    logic           w_tag_nxt;
    logic           w_ret_nxt;
    logic           w_ovf_nxt;
    logic           w_unf_nxt;
    logic           w_we;
    logic [IW-1:0]  w_widx;

    // DEPTH is a power of two, so the low IW bits of the count are count mod DEPTH.
    assign w_cnt_lo    = r_cnt[IW-1:0];
    assign w_top_idx   = r_base + w_cnt_lo - IW'(1);
    assign w_below_idx = w_top_idx - IW'(1);
    assign w_wr_idx    = r_base + w_cnt_lo;
    assign w_old       = r_mem[w_top_idx];
    assign w_below     = r_mem[w_below_idx];
    assign w_oldest    = r_mem[r_base];
    assign w_is_full   = (r_cnt == C_DEPTH);
    assign w_is_empty  = (r_cnt == '0);

    // Operation decode: flush first, then {push,pop}; computes next state and
    // the next registered top so outputs reflect the operation one edge later.
    always_comb begin
        w_base_nxt = r_base;
        w_cnt_nxt  = r_cnt;
        w_nest_nxt = r_nest;
        w_top_nxt  = r_top;
        w_tag_nxt  = r_top_irq;
        w_ret_nxt  = 1'b0;
        w_ovf_nxt  = r_ovf & ~bus.err_clr;
        w_unf_nxt  = r_unf & ~bus.err_clr;
        w_we       = 1'b0;
        w_widx     = w_wr_idx;

        if (bus.flush) begin
            w_cnt_nxt  = '0;
            w_nest_nxt = '0;
            w_top_nxt  = '0;
            w_tag_nxt  = 1'b0;
        end else if (bus.push && (!bus.pop || w_is_empty)) begin
            // Plain push; push+pop on an empty stack lands here too.
            if (!w_is_full) begin
                w_we       = 1'b1;
                w_widx     = w_wr_idx;
                w_cnt_nxt  = r_cnt + C_ONE;
                w_nest_nxt = r_nest + PW'(bus.push_irq);
                w_top_nxt  = bus.push_data;
                w_tag_nxt  = bus.push_irq;
            end else if (OVF_MODE == 0) begin
                w_ovf_nxt  = 1'b1;
            end else begin
                // Full ring: the oldest slot is reused as the new top.
                w_we       = 1'b1;
                w_widx     = r_base;
                w_base_nxt = r_base + IW'(1);
                w_nest_nxt = r_nest - PW'(w_oldest[AW]) + PW'(bus.push_irq);
                w_top_nxt  = bus.push_data;
                w_tag_nxt  = bus.push_irq;
                w_ovf_nxt  = 1'b1;
            end
        end else if (bus.push && bus.pop) begin
            // Replace top in place; the departing entry may end an interrupt.
            w_we       = 1'b1;
            w_widx     = w_top_idx;
            w_nest_nxt = r_nest - PW'(w_old[AW]) + PW'(bus.push_irq);
            w_ret_nxt  = w_old[AW];
            w_top_nxt  = bus.push_data;
            w_tag_nxt  = bus.push_irq;
        end else if (bus.pop) begin
            if (w_is_empty) begin
                w_unf_nxt = 1'b1;
            end else begin
                w_cnt_nxt  = r_cnt - C_ONE;
                w_nest_nxt = r_nest - PW'(w_old[AW]);
                w_ret_nxt  = w_old[AW];
                if (r_cnt == C_ONE) begin
                    w_top_nxt = '0;
                    w_tag_nxt = 1'b0;
                end else begin
                    w_top_nxt = w_below[AW-1:0];
                    w_tag_nxt = w_below[AW];
                end
            end
        end
    end

    // Entry storage; contents after reset are don't-care so no reset here.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_widx] <= {bus.push_irq, bus.push_data};
        end
    end

    // Control and status registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base    <= '0;
            r_cnt     <= '0;
            r_nest    <= '0;
            r_top     <= '0;
            r_top_irq <= 1'b0;
            r_ret     <= 1'b0;
            r_ovf     <= 1'b0;
            r_unf     <= 1'b0;
            r_full    <= 1'b0;
            r_empty   <= 1'b1;
        end else begin
            r_base    <= w_base_nxt;
            r_cnt     <= w_cnt_nxt;
            r_nest    <= w_nest_nxt;
            r_top     <= w_top_nxt;
            r_top_irq <= w_tag_nxt;
            r_ret     <= w_ret_nxt;
            r_ovf     <= w_ovf_nxt;
            r_unf     <= w_unf_nxt;
            r_full    <= (w_cnt_nxt == C_DEPTH);
            r_empty   <= (w_cnt_nxt == '0);
        end
    end

    assign bus.top      = r_top;
    assign bus.top_irq  = r_top_irq;
    assign bus.depth    = r_cnt;
    assign bus.full     = r_full;
    assign bus.empty    = r_empty;
    assign bus.irq_nest = r_nest;
    assign bus.irq_ret  = r_ret;
    assign bus.ovf_err  = r_ovf;
    assign bus.unf_err  = r_unf;
endmodule
`default_nettype wire

// File: tb/tb_ret_stack_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ret_stack_ctrl
//  Brief    : Self-checking bench: two DEPTH=4 stacks (drop and circular
//             overflow) share one stimulus stream; a directed vector table,
//             an asynchronous-reset sequence and a random phase are checked
//             against a queue-based model of the stack rules.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ret_stack_ctrl;
    localparam int AW = 15;
    localparam int DP = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          t_push = 1'b0, t_pop = 1'b0, t_flush = 1'b0, t_clr = 1'b0, t_irq = 1'b0;
    logic [AW-1:0] t_data = '0;

    int n_checks = 0;
    int n_errors = 0;

    ret_stack_if #(.AW(AW), .DEPTH(DP)) if0 ();
    ret_stack_if #(.AW(AW), .DEPTH(DP)) if1 ();

    assign if0.push = t_push;   assign if1.push = t_push;
    assign if0.pop = t_pop;     assign if1.pop = t_pop;
    assign if0.push_data = t_data; assign if1.push_data = t_data;
    assign if0.push_irq = t_irq;   assign if1.push_irq = t_irq;
    assign if0.flush = t_flush; assign if1.flush = t_flush;
    assign if0.err_clr = t_clr; assign if1.err_clr = t_clr;

    ret_stack_ctrl #(.AW(AW), .DEPTH(DP), .OVF_MODE(0)) u_drop (.clk(clk), .rst(rst), .bus(if0));
    ret_stack_ctrl #(.AW(AW), .DEPTH(DP), .OVF_MODE(1)) u_circ (.clk(clk), .rst(rst), .bus(if1));

    always #5 clk = ~clk;

    // Reference model: a queue of {tag,addr}, back = top of stack.
    logic [AW:0] q0[$];
    logic [AW:0] q1[$];
    bit m_ovf0, m_unf0, m_ret0, m_ovf1, m_unf1, m_ret1;

    task automatic model_one(input bit circ, inout logic [AW:0] q[$],
                             inout bit ovf, inout bit unf, output bit ret);
        ret = 1'b0;
        if (t_clr) begin ovf = 1'b0; unf = 1'b0; end
        if (t_flush) begin
            q.delete();
        end else if (t_push && t_pop && q.size() > 0) begin
            ret = q[q.size()-1][AW];
            q[q.size()-1] = {t_irq, t_data};
        end else if (t_push) begin
            if (q.size() < DP) q.push_back({t_irq, t_data});
            else begin
                ovf = 1'b1;
                if (circ) begin
                    void'(q.pop_front());
                    q.push_back({t_irq, t_data});
                end
            end
        end else if (t_pop) begin
            if (q.size() > 0) begin
                ret = q[q.size()-1][AW];
                void'(q.pop_back());
            end else unf = 1'b1;
        end
    endtask

    task automatic model_reset();
        q0.delete(); q1.delete();
        m_ovf0 = 0; m_unf0 = 0; m_ret0 = 0;
        m_ovf1 = 0; m_unf1 = 0; m_ret1 = 0;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag, input logic [AW:0] q[$],
                               input bit ovf, input bit unf, input bit ret,
                               input logic [AW-1:0] top, input logic ti,
                               input logic [2:0] dep, input logic fu, input logic em,
                               input logic [2:0] nest, input logic r,
                               input logic o, input logic u);
        int et, etag, en;
        et = 0; etag = 0; en = 0;
        if (q.size() > 0) begin
            et   = int'(q[q.size()-1][AW-1:0]);
            etag = int'(q[q.size()-1][AW]);
        end
        foreach (q[i]) en += int'(q[i][AW]);
        chk({tag, ".top"},      int'(top),  et);
        chk({tag, ".top_irq"},  int'(ti),   etag);
        chk({tag, ".depth"},    int'(dep),  q.size());
        chk({tag, ".full"},     int'(fu),   (q.size() == DP) ? 1 : 0);
        chk({tag, ".empty"},    int'(em),   (q.size() == 0) ? 1 : 0);
        chk({tag, ".irq_nest"}, int'(nest), en);
        chk({tag, ".irq_ret"},  int'(r),    int'(ret));
        chk({tag, ".ovf_err"},  int'(o),    int'(ovf));
        chk({tag, ".unf_err"},  int'(u),    int'(unf));
    endtask

    task automatic check_both();
        check_model("drop", q0, m_ovf0, m_unf0, m_ret0, if0.top, if0.top_irq, if0.depth,
                    if0.full, if0.empty, if0.irq_nest, if0.irq_ret, if0.ovf_err, if0.unf_err);
        check_model("circ", q1, m_ovf1, m_unf1, m_ret1, if1.top, if1.top_irq, if1.depth,
                    if1.full, if1.empty, if1.irq_nest, if1.irq_ret, if1.ovf_err, if1.unf_err);
    endtask

    // One clock: inputs already driven, advance model at the edge, sample #1 later.
    task automatic step();
        @(posedge clk);
        model_one(1'b0, q0, m_ovf0, m_unf0, m_ret0);
        model_one(1'b1, q1, m_ovf1, m_unf1, m_ret1);
        #1;
        check_both();
    endtask

    task automatic drive(input bit p, input bit po, input bit f, input bit c,
                         input bit irq, input logic [AW-1:0] d);
        t_push = p; t_pop = po; t_flush = f; t_clr = c; t_irq = irq; t_data = d;
    endtask

    typedef struct {
        bit push, pop, flush, clr, irq;
        logic [AW-1:0] data, top0, top1;
        int dep0, dep1, nest0, nest1;
        bit ret0, ret1, ovf0, ovf1, unf;
    } vec_t;

    vec_t tbl[30];

    function automatic vec_t mk(int p, int po, int f, int c, int irq, int d,
                                int t0, int t1, int d0, int d1, int n0, int n1,
                                int r0, int r1, int o0, int o1, int u);
        vec_t v;
        v.push = p[0]; v.pop = po[0]; v.flush = f[0]; v.clr = c[0]; v.irq = irq[0];
        v.data = d[AW-1:0]; v.top0 = t0[AW-1:0]; v.top1 = t1[AW-1:0];
        v.dep0 = d0; v.dep1 = d1; v.nest0 = n0; v.nest1 = n1;
        v.ret0 = r0[0]; v.ret1 = r1[0]; v.ovf0 = o0[0]; v.ovf1 = o1[0]; v.unf = u[0];
        return v;
    endfunction

    initial begin
        //            pu po fl cl iq data    top0   top1  d0 d1 n0 n1 r0 r1 o0 o1 u
        tbl[0]  = mk(1, 0, 0, 0, 0, 'h10,   'h10,  'h10,  1, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 0, 0, 0, 'h20,   'h20,  'h20,  2, 2, 0, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(1, 0, 0, 0, 0, 'h30,   'h30,  'h30,  3, 3, 0, 0, 0, 0, 0, 0, 0);
        tbl[3]  = mk(0, 1, 0, 0, 0, 0,      'h20,  'h20,  2, 2, 0, 0, 0, 0, 0, 0, 0);
        tbl[4]  = mk(0, 1, 0, 0, 0, 0,      'h10,  'h10,  1, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[5]  = mk(0, 1, 0, 0, 0, 0,      0,     0,     0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[6]  = mk(1, 0, 0, 0, 1, 'h100,  'h100, 'h100, 1, 1, 1, 1, 0, 0, 0, 0, 0);
        tbl[7]  = mk(1, 0, 0, 0, 0, 'h200,  'h200, 'h200, 2, 2, 1, 1, 0, 0, 0, 0, 0);
        tbl[8]  = mk(0, 1, 0, 0, 0, 0,      'h100, 'h100, 1, 1, 1, 1, 0, 0, 0, 0, 0);
        tbl[9]  = mk(0, 1, 0, 0, 0, 0,      0,     0,     0, 0, 0, 0, 1, 1, 0, 0, 0);
        tbl[10] = mk(0, 0, 0, 0, 0, 0,      0,     0,     0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[11] = mk(1, 0, 0, 0, 1, 1,      1,     1,     1, 1, 1, 1, 0, 0, 0, 0, 0);
        tbl[12] = mk(1, 0, 0, 0, 0, 2,      2,     2,     2, 2, 1, 1, 0, 0, 0, 0, 0);
        tbl[13] = mk(1, 0, 0, 0, 0, 3,      3,     3,     3, 3, 1, 1, 0, 0, 0, 0, 0);
        tbl[14] = mk(1, 0, 0, 0, 0, 4,      4,     4,     4, 4, 1, 1, 0, 0, 0, 0, 0);
        tbl[15] = mk(1, 0, 0, 0, 0, 5,      4,     5,     4, 4, 1, 0, 0, 0, 1, 1, 0);
        tbl[16] = mk(0, 0, 0, 1, 0, 0,      4,     5,     4, 4, 1, 0, 0, 0, 0, 0, 0);
        tbl[17] = mk(0, 1, 0, 0, 0, 0,      3,     4,     3, 3, 1, 0, 0, 0, 0, 0, 0);
        tbl[18] = mk(0, 1, 0, 0, 0, 0,      2,     3,     2, 2, 1, 0, 0, 0, 0, 0, 0);
        tbl[19] = mk(0, 1, 0, 0, 0, 0,      1,     2,     1, 1, 1, 0, 0, 0, 0, 0, 0);
        tbl[20] = mk(0, 1, 0, 0, 0, 0,      0,     0,     0, 0, 0, 0, 1, 0, 0, 0, 0);
        tbl[21] = mk(0, 1, 0, 0, 0, 0,      0,     0,     0, 0, 0, 0, 0, 0, 0, 0, 1);
        tbl[22] = mk(1, 0, 0, 0, 1, 7,      7,     7,     1, 1, 1, 1, 0, 0, 0, 0, 1);
        tbl[23] = mk(1, 1, 0, 0, 0, 9,      9,     9,     1, 1, 0, 0, 1, 1, 0, 0, 1);
        tbl[24] = mk(0, 1, 0, 1, 0, 0,      0,     0,     0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[25] = mk(0, 1, 0, 1, 0, 0,      0,     0,     0, 0, 0, 0, 0, 0, 0, 0, 1);
        tbl[26] = mk(1, 0, 0, 0, 0, 'h11,   'h11,  'h11,  1, 1, 0, 0, 0, 0, 0, 0, 1);
        tbl[27] = mk(1, 0, 0, 0, 1, 'h12,   'h12,  'h12,  2, 2, 1, 1, 0, 0, 0, 0, 1);
        tbl[28] = mk(1, 0, 1, 0, 0, 'h13,   0,     0,     0, 0, 0, 0, 0, 0, 0, 0, 1);
        tbl[29] = mk(1, 1, 0, 0, 1, 'h15,   'h15,  'h15,  1, 1, 1, 1, 0, 0, 0, 0, 1);

        // Reset state.
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_both();

        // Directed vectors.
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            drive(tbl[i].push, tbl[i].pop, tbl[i].flush, tbl[i].clr, tbl[i].irq, tbl[i].data);
            step();
            chk($sformatf("vec%0d.top0", i),  int'(if0.top),      int'(tbl[i].top0));
            chk($sformatf("vec%0d.top1", i),  int'(if1.top),      int'(tbl[i].top1));
            chk($sformatf("vec%0d.dep0", i),  int'(if0.depth),    tbl[i].dep0);
            chk($sformatf("vec%0d.dep1", i),  int'(if1.depth),    tbl[i].dep1);
            chk($sformatf("vec%0d.nest0", i), int'(if0.irq_nest), tbl[i].nest0);
            chk($sformatf("vec%0d.nest1", i), int'(if1.irq_nest), tbl[i].nest1);
            chk($sformatf("vec%0d.ret0", i),  int'(if0.irq_ret),  int'(tbl[i].ret0));
            chk($sformatf("vec%0d.ret1", i),  int'(if1.irq_ret),  int'(tbl[i].ret1));
            chk($sformatf("vec%0d.ovf0", i),  int'(if0.ovf_err),  int'(tbl[i].ovf0));
            chk($sformatf("vec%0d.ovf1", i),  int'(if1.ovf_err),  int'(tbl[i].ovf1));
            chk($sformatf("vec%0d.unf0", i),  int'(if0.unf_err),  int'(tbl[i].unf));
            chk($sformatf("vec%0d.unf1", i),  int'(if1.unf_err),  int'(tbl[i].unf));
        end

        // Asynchronous reset mid-stream with depth 3 and errors set.
        @(negedge clk); drive(0, 0, 1, 0, 0, 0); step();
        @(negedge clk); drive(0, 1, 0, 0, 0, 0); step();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); drive(1, 0, 0, 0, 1, AW'(32'h40 + i)); step();
        end
        chk("pre_rst.depth", int'(if0.depth), 3);
        chk("pre_rst.unf",   int'(if0.unf_err), 1);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("arst.depth0", int'(if0.depth), 0);
        chk("arst.depth1", int'(if1.depth), 0);
        chk("arst.top0",   int'(if0.top), 0);
        chk("arst.empty0", int'(if0.empty), 1);
        chk("arst.full0",  int'(if0.full), 0);
        chk("arst.nest1",  int'(if1.irq_nest), 0);
        chk("arst.unf0",   int'(if0.unf_err), 0);
        chk("arst.unf1",   int'(if1.unf_err), 0);
        chk("arst.tag0",   int'(if0.top_irq), 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_both();

        // Random phase against the model.
        for (int i = 0; i < 3000; i++) begin
            int r;
            @(negedge clk);
            r = $urandom_range(0, 99);
            drive(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 45),
                  (r < 2), (r >= 2 && r < 6), $urandom_range(0, 1), AW'($urandom));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end
endmodule
`default_nettype wire
